// File: rtl/ula_pkg.sv
// Shared types for the streaming ALU.
//   op_e    : 4-bit opcode encoding
//   state_e : LOAD (collect operand beats), EXEC (compute), SEND (stream result)
package ula_pkg;

  typedef enum logic [3:0] {
    OP_NOT  = 4'b0000,
    OP_AND  = 4'b0001,
    OP_PASS = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_ADD  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_INC  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_DIV  = 4'b1001,
    OP_MULL = 4'b1010
  } op_e;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EXEC = 2'd1,
    SEND = 2'd2
  } state_e;

endpackage

// File: rtl/ula_iter_div.sv
// Restoring divider, one quotient bit per cycle, fixed W-cycle latency.
//   clk, reset : clock, async active-high reset
//   clr        : synchronous abort, returns to idle
//   start      : load a/b and perform the first step in the same cycle
//   busy       : steps 2..W in progress
//   done       : the final step completes at the coming clock edge
//   quot, rem  : results, held until the next start/clr
//   dz         : divisor was zero (quot all ones, rem = a fall out naturally)
module ula_iter_div #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         dz
);
  localparam int CW = $clog2(W);

  logic [W-1:0]  r_q, d_q, b_q;
  logic [CW-1:0] cnt;
  logic          dz_q;

  logic [W-1:0]  src_r, src_d, src_b, r_nxt, d_nxt;
  logic [W:0]    trial;
  logic          ge;

  // The dividend shifts out of d's top while quotient bits shift in at the bottom.
  always_comb begin
    src_r = start ? '0 : r_q;
    src_d = start ? a  : d_q;
    src_b = start ? b  : b_q;
    trial = {src_r, src_d[W-1]};
    ge    = trial >= {1'b0, src_b};
    // trial < 2*b, so the difference always fits in W bits
    r_nxt = ge ? (trial[W-1:0] - src_b) : trial[W-1:0];
    d_nxt = {src_d[W-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0; d_q <= '0; b_q <= '0; cnt <= '0; busy <= 1'b0; dz_q <= 1'b0;
    end else if (clr) begin
      r_q <= '0; d_q <= '0; b_q <= '0; cnt <= '0; busy <= 1'b0; dz_q <= 1'b0;
    end else if (start) begin
      r_q  <= r_nxt;
      d_q  <= d_nxt;
      b_q  <= b;
      dz_q <= (b == '0);
      cnt  <= CW'(1);
      busy <= 1'b1;
    end else if (busy) begin
      r_q <= r_nxt;
      d_q <= d_nxt;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(W-1)) busy <= 1'b0;
    end
  end

  assign done = busy && (cnt == CW'(W-1));
  assign quot = d_q;
  assign rem  = r_q;
  assign dz   = dz_q;

endmodule

// File: rtl/ula_stream_alu.sv
// Handshaked streaming ALU: assembles OP_W-bit A/B from BEATS bus beats (low
// beat first), executes one opcode, streams the RES_W-bit result out over
// OBEATS beats (low beat first).
//   clk, reset          : clock, async active-high reset
//   en                  : sync enable; low aborts to LOAD and clears counters
//   in_valid/in_ready   : input beat handshake (a_data, b_data, op on beat 0)
//   out_valid/out_ready : result beat handshake (out_data, out_last)
//   flag_zero, flag_dz  : result==0 / divide-by-zero, valid with out_valid
// Optional feature macro: ULA_STREAM_DIV_EN enables the iterative divider for
// opcode 1001; without it that opcode returns 0 in one cycle.
module ula_stream_alu
  import ula_pkg::*;
#(
  parameter int BUS_W = 16,
  parameter int BEATS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] a_data,
  input  logic [BUS_W-1:0] b_data,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_last,
  output logic             flag_zero,
  output logic             flag_dz
);
  localparam int OP_W   = BUS_W * BEATS;
  localparam int RES_W  = 2 * OP_W;
  localparam int OBEATS = 2 * BEATS;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OW     = $clog2(OBEATS);

  state_e            state, state_nxt;
  logic [BW-1:0]     ibeat;
  logic [OW-1:0]     obeat;
  logic [OP_W-1:0]   a_q, b_q;
  op_e               op_q;
  logic [RES_W-1:0]  res_q, alu_res, res_word;
  logic              dz_w, div_wait, in_fire, out_fire;

  assign in_ready  = (state == LOAD) && en;
  assign out_valid = (state == SEND);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // ALU: every result is zero-extended to RES_W via fixed-width temporaries
  logic [OP_W:0]      sum_w, inc_w;
  logic [OP_W-1:0]    diff_w;
  logic [2*BUS_W-1:0] mull_w;
  always_comb begin
    sum_w   = {1'b0, a_q} + {1'b0, b_q};
    inc_w   = {1'b0, a_q} + (OP_W+1)'(1);
    diff_w  = a_q - b_q;
    mull_w  = {{BUS_W{1'b0}}, a_q[BUS_W-1:0]} * {{BUS_W{1'b0}}, b_q[BUS_W-1:0]};
    alu_res = '0;
    case (op_q)
      OP_NOT:  alu_res = {{OP_W{1'b0}}, ~a_q};
      OP_AND:  alu_res = {{OP_W{1'b0}}, a_q & b_q};
      OP_PASS: alu_res = {{OP_W{1'b0}}, a_q};
      OP_OR:   alu_res = {{OP_W{1'b0}}, a_q | b_q};
      OP_XOR:  alu_res = {{OP_W{1'b0}}, a_q ^ b_q};
      OP_ADD:  alu_res = RES_W'(sum_w);
      OP_SUB:  alu_res = RES_W'(diff_w);
      OP_INC:  alu_res = RES_W'(inc_w);
      OP_MUL:  alu_res = {{OP_W{1'b0}}, a_q} * {{OP_W{1'b0}}, b_q};
      OP_MULL: alu_res = RES_W'(mull_w);
      default: alu_res = '0;
    endcase
  end

`ifdef ULA_STREAM_DIV_EN
  logic            dv_start, dv_busy, dv_done, dv_dz;
  logic [OP_W-1:0] dv_quot, dv_rem;

  // Start only on the first EXEC cycle; the divider then runs to completion.
  assign dv_start = en && (state == EXEC) && (op_q == OP_DIV) && !dv_busy;

  ula_iter_div #(.W(OP_W)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (!en),
    .start (dv_start),
    .a     (a_q),
    .b     (b_q),
    .busy  (dv_busy),
    .done  (dv_done),
    .quot  (dv_quot),
    .rem   (dv_rem),
    .dz    (dv_dz)
  );

  // Divider results stay held in its registers through SEND.
  assign res_word = (op_q == OP_DIV) ? {dv_rem, dv_quot} : res_q;
  assign dz_w     = (op_q == OP_DIV) && dv_dz;
  assign div_wait = (op_q == OP_DIV) && !dv_done;
`else
  assign res_word = res_q;
  assign dz_w     = 1'b0;
  assign div_wait = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (!en) state_nxt = LOAD;
    else begin
      case (state)
        LOAD:    if (in_fire && ibeat == BW'(BEATS-1)) state_nxt = EXEC;
        EXEC:    if (!div_wait) state_nxt = SEND;
        SEND:    if (out_fire && out_last) state_nxt = LOAD;
        default: state_nxt = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
      ibeat <= '0;
      obeat <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_NOT;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      if (!en) begin
        ibeat <= '0;
        obeat <= '0;
      end else begin
        case (state)
          LOAD: if (in_fire) begin
            for (int i = 0; i < BEATS; i++)
              if (ibeat == BW'(i)) begin
                a_q[i*BUS_W +: BUS_W] <= a_data;
                b_q[i*BUS_W +: BUS_W] <= b_data;
              end
            if (ibeat == '0) op_q <= op_e'(op);
            ibeat <= (ibeat == BW'(BEATS-1)) ? '0 : ibeat + 1'b1;
          end
          EXEC: res_q <= alu_res;
          SEND: if (out_fire) obeat <= (obeat == OW'(OBEATS-1)) ? '0 : obeat + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Output serialiser: all outputs derive from registered state, so they hold
  // steady while the consumer stalls.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (out_valid) begin
      for (int i = 0; i < OBEATS; i++)
        if (obeat == OW'(i)) out_data = res_word[i*BUS_W +: BUS_W];
      out_last = (obeat == OW'(OBEATS-1));
    end
  end

  assign flag_zero = out_valid && (res_word == '0);
  assign flag_dz   = out_valid && dz_w;

endmodule

// File: tb/tb_ula_stream_alu.sv
module tb_ula_stream_alu;
  localparam int BUS_W = 16;
  localparam int BEATS = 2;
  localparam int OP_W  = 32;
`ifdef ULA_STREAM_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 0, reset = 1, en = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, out_last, flag_zero, flag_dz;
  logic [15:0] a_data = 0, b_data = 0, out_data;
  logic [3:0]  op = 0;

  int checks = 0, errors = 0, cyc = 0;

  ula_stream_alu #(.BUS_W(BUS_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .b_data(b_data), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .flag_zero(flag_zero), .flag_dz(flag_dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on 64-bit integers.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] o, output bit dz);
    longint unsigned ua = 64'(a), ub = 64'(b);
    dz = 0;
    case (o)
      4'd0:  return ~ua & 64'hFFFF_FFFF;
      4'd1:  return ua & ub;
      4'd2:  return ua;
      4'd3:  return ua | ub;
      4'd4:  return ua ^ ub;
      4'd5:  return ua + ub;
      4'd6:  return (ua - ub) & 64'hFFFF_FFFF;
      4'd7:  return ua + 1;
      4'd8:  return ua * ub;
      4'd9:  begin
        if (!DIV_EN) return 0;
        if (ub == 0) begin dz = 1; return (ua << 32) | 64'hFFFF_FFFF; end
        return ((ua % ub) << 32) | (ua / ub);
      end
      4'd10: return (ua & 64'hFFFF) * (ub & 64'hFFFF);
      default: return 0;
    endcase
  endfunction

  task automatic send_txn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o,
                          input int nbeats, output int t0);
    int n;
    t0 = 0;
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      in_valid = 1; a_data = a[i*16 +: 16]; b_data = b[i*16 +: 16];
      op = (i == 0) ? o : ~o;  // op must only be taken from beat 0
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
        checks++; errors++;
        $display("FAIL send_timeout: got in_ready=0 required 1");
      end
      if (i == 0) t0 = cyc;
      @(posedge clk);
    end
    #1 in_valid = 0;
  endtask

  task automatic recv_chk(input string tag, input logic [63:0] exp, input bit ez, input bit edz,
                          input int t0, input int lat, input int sb, input int sn, input bit noise);
    int beat = 0, n = 0, st = sn;
    bit first = 1;
    logic [63:0] e = exp;
    while (beat < 4 && n < 300) begin
      @(negedge clk);
      if (noise) begin
        in_valid = 1; a_data = 16'($urandom); b_data = 16'($urandom); op = 4'($urandom);
      end
      if (out_valid) begin
        if (first) begin chk({tag, ".latency"}, 64'(cyc - t0), 64'(lat)); first = 0; end
        chk($sformatf("%s.data%0d", tag, beat), 64'(out_data), 64'(e[beat*16 +: 16]));
        chk($sformatf("%s.last%0d", tag, beat), 64'(out_last), 64'(beat == 3));
        chk($sformatf("%s.zero%0d", tag, beat), 64'(flag_zero), 64'(ez));
        chk($sformatf("%s.dz%0d", tag, beat), 64'(flag_dz), 64'(edz));
        if (beat == sb && st > 0) begin out_ready = 0; st--; end
        else begin out_ready = 1; beat++; end
      end else out_ready = 1;
      n++;
    end
    if (beat < 4) begin
      checks++; errors++;
      $display("FAIL %s.timeout: got %0d beats required 4", tag, beat);
    end
    @(posedge clk);
    #1 in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk({tag, ".in_ready_after"}, 64'(in_ready), 64'd1);
    chk({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] o, input logic [63:0] exp, input bit ez, input bit edz,
                     input int sb, input int sn, input bit noise);
    int t0;
    int lat = (o == 4'd9 && DIV_EN) ? BEATS + OP_W : BEATS + 1;
    send_txn(a, b, o, BEATS, t0);
    recv_chk(tag, exp, ez, edz, t0, lat, sb, sn, noise);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [63:0] res;
    bit          z, dz;
    int          sb, sn;
  } vec_t;

  vec_t tv[14];

  initial begin
    int t0, n, consumed;
    bit dz;
    logic [31:0] ra, rb;
    logic [3:0]  ro;
    logic [63:0] rexp;

    tv[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'h5, 64'h0000_0001_0000_0000, 0, 0, -1, 0};
    tv[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h8, 64'hFFFF_FFFE_0000_0001, 0, 0, -1, 0};
    tv[2]  = '{32'd5, 32'd5, 4'h6, 64'h0, 1, 0, 2, 3};
    tv[3]  = '{32'd100, 32'd7, 4'h9, DIV_EN ? 64'h0000_0002_0000_000E : 64'h0, !DIV_EN, 0, -1, 0};
    tv[4]  = '{32'h1234, 32'h0, 4'h9, DIV_EN ? 64'h0000_1234_FFFF_FFFF : 64'h0, !DIV_EN, DIV_EN, -1, 0};
    tv[5]  = '{32'h0, 32'h0, 4'h0, 64'h0000_0000_FFFF_FFFF, 0, 0, -1, 0};
    tv[6]  = '{32'hFFFF_FFFF, 32'h0, 4'h7, 64'h0000_0001_0000_0000, 0, 0, 1, 2};
    tv[7]  = '{32'h1234_FFFF, 32'hABCD_0002, 4'hA, 64'h0000_0000_0001_FFFE, 0, 0, -1, 0};
    tv[8]  = '{32'h1234_5678, 32'h9ABC_DEF0, 4'hF, 64'h0, 1, 0, -1, 0};
    tv[9]  = '{32'hF0F0_1234, 32'hFF00_00FF, 4'h1, 64'h0000_0000_F000_0034, 0, 0, 0, 1};
    tv[10] = '{32'h0F00_0001, 32'h00F0_1000, 4'h3, 64'h0000_0000_0FF0_1001, 0, 0, -1, 0};
    tv[11] = '{32'hFFFF_0000, 32'hFF00_FF00, 4'h4, 64'h0000_0000_00FF_FF00, 0, 0, 3, 2};
    tv[12] = '{32'h8765_4321, 32'h1111_1111, 4'h2, 64'h0000_0000_8765_4321, 0, 0, -1, 0};
    tv[13] = '{32'h0, 32'h1, 4'h6, 64'h0000_0000_FFFF_FFFF, 0, 0, -1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 0);
    chk("rst.out_data", 64'(out_data), 0);
    chk("rst.out_last", 64'(out_last), 0);
    chk("rst.flags", 64'({flag_zero, flag_dz}), 0);
    reset = 0;
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 1);

    // Directed vectors
    for (int i = 0; i < 14; i++)
      run($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].op, tv[i].res, tv[i].z, tv[i].dz,
          tv[i].sb, tv[i].sn, 0);

    // Reset asserted while result beat 2 is presented
    send_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h8, BEATS, t0);
    n = 0; consumed = 0;
    while (consumed < 2 && n < 50) begin
      @(negedge clk); out_ready = 1;
      if (out_valid) consumed++;
      n++;
    end
    chk("rstseq.beats", 64'(consumed), 2);
    @(negedge clk);
    chk("rstseq.beat2", 64'(out_data), 64'hFFFE);
    reset = 1;
    #1;
    chk("rstseq.out_valid", 64'(out_valid), 0);
    chk("rstseq.out_data", 64'(out_data), 0);
    chk("rstseq.out_last", 64'(out_last), 0);
    @(negedge clk); reset = 0;
    #1 chk("rstseq.in_ready", 64'(in_ready), 1);

    // en low after a single input beat: the stale beat must not leak
    send_txn(32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'h8, 1, t0);
    @(negedge clk); en = 0;
    #1 chk("enseq.in_ready_low", 64'(in_ready), 0);
    @(negedge clk); en = 1;
    run("enseq", 32'h0001_0002, 32'h0003_0004, 4'h5, 64'h0000_0000_0004_0006, 0, 0, -1, 0, 0);

    // Randomized against the reference model, with input noise while busy
    for (int k = 0; k < 40; k++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rexp = model(ra, rb, ro, dz);
      run($sformatf("rnd%0d", k), ra, rb, ro, rexp, rexp == 0, dz,
          $urandom_range(0, 3), $urandom_range(0, 3), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

endmodule
